// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - opcodes and FSM state encodings shared by the logic-op issuer
package logic_op_pkg;

    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_NAND    = 3'b001;
    localparam logic [2:0] OP_OR      = 3'b010;
    localparam logic [2:0] OP_NOR     = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_XNOR    = 3'b101;
    localparam logic [2:0] OP_NOTA    = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_model.sv
// rtl/logic_op_model.sv - combinational golden function of the 16-bit logic unit
module logic_op_model
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_NAND: result = ~(a & b);
            OP_OR:   result = a | b;
            OP_NOR:  result = ~(a | b);
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_NOTA: result = ~a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_issuer.sv
// rtl/logic_op_issuer.sv - single-outstanding command issuer for the logic unit (optional checker: LOGIC_ISSUER_SCOREBOARD_EN)
module logic_op_issuer
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LAT   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [2:0]       log_op,
    output logic [WIDTH-1:0] log_a,
    output logic [WIDTH-1:0] log_b,
    input  logic [WIDTH-1:0] log_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = 4;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               sample;

    assign accept = cmd_valid && cmd_ready;
    assign sample = (state == ST_DRIVE) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = (cmd_op == OP_ILLEGAL) ? ST_RESP : ST_DRIVE;
            ST_DRIVE: if (cnt == '0) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        busy      = (state != ST_IDLE);
    end

    // Illegal commands bypass the unit entirely, so log_* keep the last issued values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_op      <= OP_AND;
            log_a       <= '0;
            log_b       <= '0;
            rsp_data    <= '0;
            rsp_tag     <= '0;
            rsp_illegal <= 1'b0;
            cnt         <= '0;
        end else begin
            if (accept) begin
                rsp_tag <= cmd_tag;
                if (cmd_op == OP_ILLEGAL) begin
                    rsp_data    <= '0;
                    rsp_illegal <= 1'b1;
                end else begin
                    log_op <= cmd_op;
                    log_a  <= cmd_a;
                    log_b  <= cmd_b;
                    cnt    <= CNT_W'(LAT - 1);
                end
            end
            if (state == ST_DRIVE) begin
                if (cnt == '0) begin
                    rsp_data    <= log_out;
                    rsp_illegal <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

`ifdef LOGIC_ISSUER_SCOREBOARD_EN
    logic [WIDTH-1:0] expected;
    logic             err_q;

    logic_op_model #(.WIDTH(WIDTH)) u_model (
        .op     (log_op),
        .a      (log_a),
        .b      (log_b),
        .result (expected)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            err_q <= 1'b0;
        else if (sample && expected != log_out) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
